// File: rtl/spi_slave_regif_if.sv
// SPI pin and register-bus bundle for spi_slave_regif.
// The slave modport is the target's view; master is the driver's view.
interface spi_slave_regif_if #(
  parameter int ADDR_W = 3
);
  logic              SPI_SCK_i;
  logic              SPI_CSn_i;
  logic              SPI_MOSI_i;
  logic              SPI_MISO_o;
  logic              MISO_OE_o;
  logic [ADDR_W-1:0] AD_o;
  logic              WR_o;
  logic              RD_o;
  logic [7:0]        Data_o;
  logic [7:0]        Data_i;
  logic              BUSY_o;

  modport slave (
    input  SPI_SCK_i,
    input  SPI_CSn_i,
    input  SPI_MOSI_i,
    input  Data_i,
    output SPI_MISO_o,
    output MISO_OE_o,
    output AD_o,
    output WR_o,
    output RD_o,
    output Data_o,
    output BUSY_o
  );

  modport master (
    output SPI_SCK_i,
    output SPI_CSn_i,
    output SPI_MOSI_i,
    output Data_i,
    input  SPI_MISO_o,
    input  MISO_OE_o,
    input  AD_o,
    input  WR_o,
    input  RD_o,
    input  Data_o,
    input  BUSY_o
  );
endinterface

// File: rtl/spi_slave_regif.sv
// SPI target bridging an SPI master onto the 8-bit register bus.
// Define SPI_SLV_AUTOINC_EN for burst access with address auto-increment.
module spi_slave_regif #(
  parameter int ADDR_W    = 3,
  parameter bit CPOL      = 1'b0,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic CLK_i,
  input logic RST_N_i,
  spi_slave_regif_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_SKIP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0] r_sck_s;
  logic [1:0] r_csn_s;
  logic [1:0] r_mosi_s;
  logic       r_sck_d;
  logic [1:0] r_flush;
  logic       r_arm;

  logic       w_sck;
  logic       w_csn;
  logic       w_mosi;
  logic       w_active;
  logic       w_rise;
  logic       w_fall;
  logic       w_last;
  logic       w_cmd_done;
  logic       w_dat_done;
  logic [7:0] w_byte;

  logic [2:0]        r_bitcnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_tx_vld;
  logic              r_cmd_rd;
  logic [ADDR_W-1:0] r_ad;
  logic              r_wr;
  logic              r_rd;
  logic [7:0]        r_data;
  logic              r_miso;
`ifdef SPI_SLV_AUTOINC_EN
  logic              r_first;
`endif

  // Synchronise the asynchronous SPI pins; r_arm demands CSn seen high
  // after reset so a CSn held low through reset never starts a transfer.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_sck_s  <= {CPOL, CPOL};
      r_csn_s  <= 2'b11;
      r_mosi_s <= 2'b00;
      r_sck_d  <= CPOL;
      r_flush  <= 2'b00;
      r_arm    <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[0], bus.SPI_SCK_i};
      r_csn_s  <= {r_csn_s[0], bus.SPI_CSn_i};
      r_mosi_s <= {r_mosi_s[0], bus.SPI_MOSI_i};
      r_sck_d  <= r_sck_s[1];
      r_flush  <= {r_flush[0], 1'b1};
      r_arm    <= r_arm | (r_flush[1] & r_csn_s[1]);
    end
  end

  assign w_sck    = r_sck_s[1];
  assign w_csn    = r_csn_s[1];
  assign w_mosi   = r_mosi_s[1];
  assign w_active = ~w_csn & (r_state != S_IDLE);
  assign w_rise   = w_active & w_sck & ~r_sck_d;
  assign w_fall   = w_active & ~w_sck & r_sck_d;
  assign w_last   = w_rise & (r_bitcnt == 3'd7);
  assign w_byte   = LSB_FIRST ? {w_mosi, r_rx[7:1]}
                              : {r_rx[6:0], w_mosi};

  // State register
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and byte-boundary strobes; CSn high aborts from anywhere
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_done  = 1'b0;
    w_dat_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_arm && !w_csn) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (w_csn) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_cmd_done  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_csn) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_dat_done  = 1'b1;
`ifdef SPI_SLV_AUTOINC_EN
          w_state_nxt = S_DATA;
`else
          w_state_nxt = S_SKIP;
`endif
        end
      end
      S_SKIP: begin
        if (w_csn) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Receive shifter and bit counter, cleared whenever idle
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_bitcnt <= 3'd0;
      r_rx     <= 8'h00;
    end else if (r_state == S_IDLE) begin
      r_bitcnt <= 3'd0;
      r_rx     <= 8'h00;
    end else if (w_rise) begin
      r_bitcnt <= r_bitcnt + 3'd1;
      r_rx     <= w_byte;
    end
  end

  // Register-bus side: address, command type, write/read strobes
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_ad     <= '0;
      r_cmd_rd <= 1'b0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_data   <= 8'h00;
`ifdef SPI_SLV_AUTOINC_EN
      r_first  <= 1'b0;
`endif
    end else begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (w_cmd_done) begin
        r_ad     <= w_byte[ADDR_W-1:0];
        r_cmd_rd <= w_byte[7];
        r_rd     <= w_byte[7];
`ifdef SPI_SLV_AUTOINC_EN
        r_first  <= 1'b1;
`endif
      end
      if (w_dat_done) begin
`ifdef SPI_SLV_AUTOINC_EN
        r_first <= 1'b0;
        if (!r_cmd_rd) begin
          r_wr   <= 1'b1;
          r_data <= w_byte;
          if (!r_first) r_ad <= r_ad + 1'b1;
        end else begin
          r_ad <= r_ad + 1'b1;
          r_rd <= 1'b1;
        end
`else
        if (!r_cmd_rd) begin
          r_wr   <= 1'b1;
          r_data <= w_byte;
        end
`endif
      end
    end
  end

  // Transmit shifter: load one cycle after RD, shift on falling SCK
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_tx     <= 8'h00;
      r_tx_vld <= 1'b0;
      r_miso   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_tx     <= 8'h00;
      r_tx_vld <= 1'b0;
      r_miso   <= 1'b0;
    end else if (r_rd) begin
      r_tx     <= bus.Data_i;
      r_tx_vld <= 1'b1;
    end else if (w_fall) begin
      if (r_state == S_DATA && r_tx_vld) begin
        r_miso <= LSB_FIRST ? r_tx[0] : r_tx[7];
        r_tx   <= LSB_FIRST ? {1'b0, r_tx[7:1]}
                            : {r_tx[6:0], 1'b0};
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign bus.SPI_MISO_o = r_miso;
  assign bus.MISO_OE_o  = ~w_csn;
  assign bus.AD_o       = r_ad;
  assign bus.WR_o       = r_wr;
  assign bus.RD_o       = r_rd;
  assign bus.Data_o     = r_data;
  assign bus.BUSY_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed and randomized bench for spi_slave_regif.
// A byte-level model predicts strobes, final address and MISO bits.
module tb_spi_slave_regif;

  localparam int AW   = 3;
  localparam bit CPOL = 1'b0;
  localparam bit LSB  = 1'b0;
  localparam int HALF = 8;
`ifdef SPI_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] ad;
    logic [7:0]    d;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   wr_cyc   = 0;
  int   rise_cyc = 0;

  logic [7:0]    mem [8];
  logic [7:0]    tx_q [$];
  logic          miso_q [$];
  logic          exp_miso [$];
  ev_t           got_q [$];
  ev_t           exp_q [$];
  logic [AW-1:0] prev_ad;
  logic [AW-1:0] exp_ad;
  logic [7:0]    rx_byte;

  spi_slave_regif_if #(.ADDR_W(AW)) bus ();

  spi_slave_regif #(
    .ADDR_W   (AW),
    .CPOL     (CPOL),
    .LSB_FIRST(LSB)
  ) dut (
    .CLK_i  (clk),
    .RST_N_i(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.Data_i = mem[bus.AD_o];

  always @(negedge clk) begin
    if (rst_n && bus.WR_o) begin
      got_q.push_back({1'b1, bus.AD_o, bus.Data_o});
      wr_cyc <= cyc;
    end
    if (rst_n && bus.RD_o) got_q.push_back({1'b0, bus.AD_o, 8'h00});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sck_bits(input int nbits, input bit live);
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] b;
      int         k;
      b = tx_q[i / 8];
      k = i % 8;
      bus.SPI_SCK_i  = 1'b0;
      bus.SPI_MOSI_i = LSB ? b[k] : b[7 - k];
      repeat (HALF) @(negedge clk);
      bus.SPI_SCK_i = 1'b1;
      miso_q.push_back(bus.SPI_MISO_o);
      rise_cyc = cyc;
      if (live && i == 3) begin
        chk("oe_active", 32'(bus.MISO_OE_o), 32'd1);
        chk("busy_active", 32'(bus.BUSY_o), 32'd1);
      end
      repeat (HALF) @(negedge clk);
    end
    bus.SPI_SCK_i = CPOL;
  endtask

  task automatic model(input int nbits);
    int         nfull;
    int         j;
    int         k;
    logic [7:0] cmd;
    logic [7:0] v;
    logic [AW-1:0] a;
    exp_q.delete();
    exp_miso.delete();
    exp_ad = prev_ad;
    nfull  = nbits / 8;
    cmd    = (nfull >= 1) ? tx_q[0] : 8'h00;
    a      = cmd[AW-1:0];
    if (nfull >= 1) begin
      exp_ad = a;
      if (cmd[7]) exp_q.push_back({1'b0, a, 8'h00});
      for (int jj = 1; jj < nfull; jj++) begin
        if (!cmd[7] && (jj == 1 || AUTOINC))
          exp_q.push_back({1'b1, AW'(a + jj - 1), tx_q[jj]});
        if (cmd[7] && AUTOINC)
          exp_q.push_back({1'b0, AW'(a + jj), 8'h00});
      end
      if (exp_q.size() > 0) exp_ad = exp_q[exp_q.size() - 1].ad;
    end
    for (int i = 0; i < nbits; i++) begin
      j = i / 8;
      k = i % 8;
      v = 8'h00;
      if (j >= 1 && cmd[7] && (j == 1 || AUTOINC))
        v = mem[AW'(a + j - 1)];
      exp_miso.push_back(LSB ? v[k] : v[7 - k]);
    end
  endtask

  task automatic run_txn(input int nbits);
    int bad;
    got_q.delete();
    miso_q.delete();
    bus.SPI_CSn_i = 1'b0;
    repeat (HALF) @(negedge clk);
    sck_bits(nbits, 1'b1);
    repeat (HALF) @(negedge clk);
    bus.SPI_CSn_i = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    model(nbits);
    chk("ev_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("ev%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    bad = 0;
    for (int i = 0; i < nbits; i++)
      if (miso_q[i] !== exp_miso[i]) bad++;
    chk("miso_bits_wrong", bad, 0);
    chk("busy_idle", 32'(bus.BUSY_o), 32'd0);
    chk("oe_idle", 32'(bus.MISO_OE_o), 32'd0);
    chk("miso_idle", 32'(bus.SPI_MISO_o), 32'd0);
    chk("ad_final", 32'(bus.AD_o), 32'(exp_ad));
    prev_ad = exp_ad;
  endtask

  initial begin
    bus.SPI_SCK_i  = CPOL;
    bus.SPI_CSn_i  = 1'b1;
    bus.SPI_MOSI_i = 1'b0;
    prev_ad        = '0;
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    repeat (4) @(negedge clk);
    chk("reset_outputs",
        32'({bus.SPI_MISO_o, bus.MISO_OE_o, bus.AD_o, bus.WR_o,
             bus.RD_o, bus.Data_o, bus.BUSY_o}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    tx_q = '{8'h05, 8'hA7};
    run_txn(16);
    chk("t1_write",
        got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF,
        32'({1'b1, 3'd5, 8'hA7}));
    chk("t1_wr_latency",
        32'((wr_cyc - rise_cyc) inside {[1:4]}), 32'd1);

    mem[2] = 8'h3C;
    tx_q   = '{8'h82, 8'($urandom)};
    run_txn(16);
    rx_byte = 8'h00;
    for (int i = 8; i < 16; i++) rx_byte = {rx_byte[6:0], miso_q[i]};
    chk("t2_miso_byte", 32'(rx_byte), 32'h3C);
    chk("t2_read",
        got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF,
        32'({1'b0, 3'd2, 8'h00}));

    tx_q = '{8'h04, 8'h5A};
    run_txn(13);
    chk("t3_abort_no_strobe", got_q.size(), 0);
    tx_q = '{8'h06, 8'hC3};
    run_txn(16);
    chk("t3_after_abort",
        got_q.size() == 1 ? 32'(got_q[0]) : 32'hFFFF,
        32'({1'b1, 3'd6, 8'hC3}));

    tx_q = '{8'h07, 8'h11, 8'h22};
    run_txn(24);
    chk("t5_first_write",
        got_q.size() >= 1 ? 32'(got_q[0]) : 32'hFFFF,
        32'({1'b1, 3'd7, 8'h11}));

    tx_q = '{8'h81, 8'h00, 8'h00, 8'h00};
    got_q.delete();
    miso_q.delete();
    bus.SPI_CSn_i = 1'b0;
    repeat (HALF) @(negedge clk);
    sck_bits(12, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_outputs",
        32'({bus.SPI_MISO_o, bus.MISO_OE_o, bus.AD_o, bus.WR_o,
             bus.RD_o, bus.Data_o, bus.BUSY_o}), 32'd0);
    rst_n = 1'b1;
    got_q.delete();
    sck_bits(16, 1'b0);
    chk("rst_hold_busy", 32'(bus.BUSY_o), 32'd0);
    chk("rst_hold_events", got_q.size(), 0);
    bus.SPI_CSn_i = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    prev_ad = '0;

    for (int t = 0; t < 12; t++) begin
      int nb;
      int nbits;
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      nb = $urandom_range(2, 4);
      tx_q.delete();
      for (int i = 0; i <= nb; i++) tx_q.push_back(8'($urandom));
      nbits = nb * 8;
      if ($urandom_range(0, 2) == 0) nbits = nbits + $urandom_range(1, 7);
      repeat (4) @(negedge clk);
      run_txn(nbits);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
